sdr_arb: RTL and testbench

SDR_ARB -- requirements
Module: sdr_arb

---
 rtl/sdr_pkg.sv | 41 ++++
 rtl/sdr_arb_if.sv | 29 ++
 rtl/sdr_ref_timer.sv | 38 +++
 rtl/sdr_arb.sv | 138 +++++++++++++
 tb/tb_sdr_arb.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdr_pkg.sv
// Shared definitions for the SDRAM controller slice: arbiter state codes,
// command-bus owner codes and SDRAM command encodings used by the sequencers.
package sdr_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] owner_t;

  localparam state_t S_INIT = 3'd0;
  localparam state_t S_IDLE = 3'd1;
  localparam state_t S_REF  = 3'd2;
  localparam state_t S_RD   = 3'd3;
  localparam state_t S_WR   = 3'd4;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_RD   = 2'd1;
  localparam owner_t OWN_WR   = 2'd2;
  localparam owner_t OWN_REF  = 2'd3;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_MRS  = 4'b0000,
    CMD_REF  = 4'b0001,
    CMD_PRE  = 4'b0010,
    CMD_ACT  = 4'b0011,
    CMD_WR   = 4'b0100,
    CMD_RD   = 4'b0101,
    CMD_BST  = 4'b0110,
    CMD_NOP  = 4'b0111,
    CMD_DESL = 4'b1111
  } sdr_cmd_e;

  function automatic owner_t state_owner(input state_t st);
    case (st)
      S_REF:   return OWN_REF;
      S_RD:    return OWN_RD;
      S_WR:    return OWN_WR;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sdr_arb_if.sv
// Handshake bundle between the command-bus arbiter, the user request ports
// and the read/write/refresh sequencers.
interface sdr_arb_if;

  logic       rd_req;
  logic       wr_req;
  logic       rd_done;
  logic       wr_done;
  logic       ref_done;
  logic       rd_start;
  logic       wr_start;
  logic       ref_start;
  logic       rd_ack;
  logic       wr_ack;
  logic [1:0] owner;
  logic       busy;
  logic       err;

  modport master (
    input  rd_req, wr_req, rd_done, wr_done, ref_done,
    output rd_start, wr_start, ref_start, rd_ack, wr_ack, owner, busy, err
  );

  modport slave (
    output rd_req, wr_req, rd_done, wr_done, ref_done,
    input  rd_start, wr_start, ref_start, rd_ack, wr_ack, owner, busy, err
  );

endinterface

// File: rtl/sdr_ref_timer.sv
// Auto-refresh interval timer: raises ref_pend once per REF_CYCLES while
// init_done is high, and flags an overrun if the previous request is unserved.
module sdr_ref_timer #(
  parameter int REF_CYCLES = 1300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic ref_clr,
  output logic ref_pend,
  output logic overrun
);

  localparam int CW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc = init_done && (cnt == CW'(REF_CYCLES - 1));

  // A pending request being granted on the same edge is not an overrun.
  assign overrun = tc && ref_pend && !ref_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ref_pend <= 1'b0;
    end else if (!init_done) begin
      cnt      <= '0;
      ref_pend <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc)           ref_pend <= 1'b1;
      else if (ref_clr) ref_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sdr_arb.sv
// SDRAM command-bus arbiter: grants refresh, write and read sequencers one at
// a time, with an operation timeout. Define SDR_ARB_RR_EN for round-robin rd/wr.
//
// state  | meaning
// S_INIT | waiting for power-up init, requests ignored
// S_IDLE | arbitrating, one grant per cycle
// S_REF  | refresh sequencer owns the bus
// S_RD   | read sequencer owns the bus
// S_WR   | write sequencer owns the bus
module sdr_arb
  import sdr_pkg::*;
#(
  parameter int REF_CYCLES = 1300,
  parameter int TO_CYCLES  = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      init_done,
  sdr_arb_if.master bus
);

  localparam int TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] to_cnt;
  logic          op_state;
  logic          op_done;
  logic          to_hit;
  logic          timeout;
  logic          grant_rd;
  logic          grant_wr;
  logic          grant_ref;
  logic          pick_wr;
  logic          ref_pend;
  logic          overrun;
  logic          rd_start_q;
  logic          wr_start_q;
  logic          ref_start_q;
  logic          err_q;

`ifdef SDR_ARB_RR_EN
  logic last_wr;

  // On a rd/wr tie the side granted last time yields.
  assign pick_wr = bus.wr_req && (!bus.rd_req || !last_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_wr <= 1'b0;
    else if (grant_wr) last_wr <= 1'b1;
    else if (grant_rd) last_wr <= 1'b0;
  end
`else
  assign pick_wr = bus.wr_req;
`endif

  sdr_ref_timer #(
    .REF_CYCLES (REF_CYCLES)
  ) u_ref_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .ref_clr   (grant_ref),
    .ref_pend  (ref_pend),
    .overrun   (overrun)
  );

  assign op_state = (state == S_REF) || (state == S_RD) || (state == S_WR);
  assign op_done  = ((state == S_REF) && bus.ref_done) ||
                    ((state == S_RD)  && bus.rd_done)  ||
                    ((state == S_WR)  && bus.wr_done);
  assign to_hit   = (to_cnt == TW'(TO_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    grant_ref = 1'b0;
    timeout   = 1'b0;
    if (!init_done) begin
      state_nxt = S_INIT;
    end else begin
      case (state)
        S_INIT: state_nxt = S_IDLE;
        S_IDLE: begin
          if (ref_pend) begin
            grant_ref = 1'b1;
            state_nxt = S_REF;
          end else if (pick_wr) begin
            grant_wr  = 1'b1;
            state_nxt = S_WR;
          end else if (bus.rd_req) begin
            grant_rd  = 1'b1;
            state_nxt = S_RD;
          end
        end
        S_REF, S_RD, S_WR: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (op_done) begin
            state_nxt = S_IDLE;
          end else if (to_hit) begin
            timeout   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      to_cnt      <= '0;
      rd_start_q  <= 1'b0;
      wr_start_q  <= 1'b0;
      ref_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      to_cnt      <= (op_state && (state_nxt == state)) ? to_cnt + TW'(1) : '0;
      rd_start_q  <= grant_rd;
      wr_start_q  <= grant_wr;
      ref_start_q <= grant_ref;
      err_q       <= err_q | timeout | overrun;
    end
  end

  assign bus.rd_start  = rd_start_q;
  assign bus.rd_ack    = rd_start_q;
  assign bus.wr_start  = wr_start_q;
  assign bus.wr_ack    = wr_start_q;
  assign bus.ref_start = ref_start_q;
  assign bus.owner     = state_owner(state);
  assign bus.busy      = (state != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sdr_arb.sv
// Self-checking bench for sdr_arb: expected grants are queued as requests are
// driven and popped when start pulses appear. Honours SDR_ARB_RR_EN.
module tb_sdr_arb;
  import sdr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_b = 1'b0;
  logic init_done = 1'b0;

  sdr_arb_if ifc ();
  sdr_arb_if ifc_b ();

  sdr_arb #(.REF_CYCLES(16), .TO_CYCLES(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .bus       (ifc)
  );

  sdr_arb #(.REF_CYCLES(16), .TO_CYCLES(64)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n_b),
    .init_done (init_done),
    .bus       (ifc_b)
  );

  always #3 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_q_b[$];
  logic [1:0] slot_own[3];
  int         rd_lat = 0, wr_lat = 0, ref_lat = 0;
  int         rd_cnt = 0, wr_cnt = 0, ref_cnt = 0;
  int         wr_lat_b = 0, ref_lat_b = 0;
  int         wr_cnt_b = 0, ref_cnt_b = 0;
  bit         hold_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] pulse_of(input logic [1:0] own);
    case (own)
      OWN_RD:  return 5'b00101;
      OWN_WR:  return 5'b01010;
      OWN_REF: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] pulses_a();
    return {ifc.ref_start, ifc.wr_start, ifc.rd_start, ifc.wr_ack, ifc.rd_ack};
  endfunction

  function automatic logic [4:0] pulses_b();
    return {ifc_b.ref_start, ifc_b.wr_start, ifc_b.rd_start, ifc_b.wr_ack, ifc_b.rd_ack};
  endfunction

  // One clock: sample just after the edge, score grants, then play user/sequencer.
  task automatic cycle();
    logic [4:0] p;
    logic [1:0] e;
    @(posedge clk);
    #1;
    p = pulses_a();
    if (p != 5'b0) begin
      if (exp_q.size() == 0) chk("spurious_grant", p, 0);
      else begin
        e = exp_q.pop_front();
        chk("grant_pulses", p, pulse_of(e));
        chk("grant_owner", ifc.owner, e);
      end
    end
    p = pulses_b();
    if (p != 5'b0) begin
      if (exp_q_b.size() == 0) chk("b_spurious_grant", p, 0);
      else begin
        e = exp_q_b.pop_front();
        chk("b_grant_pulses", p, pulse_of(e));
        chk("b_grant_owner", ifc_b.owner, e);
      end
    end

    ifc.rd_done = 1'b0; ifc.wr_done = 1'b0; ifc.ref_done = 1'b0;
    if (!rst_n || !init_done) begin rd_cnt = 0; wr_cnt = 0; ref_cnt = 0; end
    if (rd_cnt > 0)  begin rd_cnt--;  if (rd_cnt == 0)  ifc.rd_done = 1'b1;  end
    if (wr_cnt > 0)  begin wr_cnt--;  if (wr_cnt == 0)  ifc.wr_done = 1'b1;  end
    if (ref_cnt > 0) begin ref_cnt--; if (ref_cnt == 0) ifc.ref_done = 1'b1; end
    if (ifc.rd_start)  rd_cnt = rd_lat;
    if (ifc.wr_start)  wr_cnt = wr_lat;
    if (ifc.ref_start) ref_cnt = ref_lat;
    if (ifc.rd_ack && !hold_req) ifc.rd_req = 1'b0;
    if (ifc.wr_ack && !hold_req) ifc.wr_req = 1'b0;

    ifc_b.wr_done = 1'b0; ifc_b.ref_done = 1'b0;
    if (!rst_n_b || !init_done) begin wr_cnt_b = 0; ref_cnt_b = 0; end
    if (wr_cnt_b > 0)  begin wr_cnt_b--;  if (wr_cnt_b == 0)  ifc_b.wr_done = 1'b1;  end
    if (ref_cnt_b > 0) begin ref_cnt_b--; if (ref_cnt_b == 0) ifc_b.ref_done = 1'b1; end
    if (ifc_b.wr_start)  wr_cnt_b = wr_lat_b;
    if (ifc_b.ref_start) ref_cnt_b = ref_lat_b;
    if (ifc_b.wr_ack) ifc_b.wr_req = 1'b0;
  endtask

  task automatic restart();
    init_done = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    ifc.rd_req = 1'b0; ifc.wr_req = 1'b0;
    ifc.rd_done = 1'b0; ifc.wr_done = 1'b0; ifc.ref_done = 1'b0;
    ifc_b.rd_req = 1'b0; ifc_b.wr_req = 1'b0;
    ifc_b.rd_done = 1'b0; ifc_b.wr_done = 1'b0; ifc_b.ref_done = 1'b0;
    slot_own = '{OWN_REF, OWN_WR, OWN_RD};

    // reset values
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_owner", ifc.owner, OWN_NONE);
    chk("rst_busy", ifc.busy, 1);
    chk("rst_err", ifc.err, 0);
    chk("rst_pulses", pulses_a(), 0);
    rst_n = 1'b1;
    cycle();
    chk("no_init_busy", ifc.busy, 1);
    chk("no_init_owner", ifc.owner, OWN_NONE);

    // single read, done four cycles after start
    init_done = 1'b1; ifc.rd_req = 1'b1; rd_lat = 4;
    exp_q.push_back(OWN_RD);
    cycle();
    chk("init_idle_busy", ifc.busy, 0);
    cycle();
    chk("rd_busy", ifc.busy, 1);
    repeat (4) cycle();
    chk("rd_owner_held", ifc.owner, OWN_RD);
    cycle();
    chk("rd_end_owner", ifc.owner, OWN_NONE);
    chk("rd_end_busy", ifc.busy, 0);
    chk("rd_sb", exp_q.size(), 0);

    // refresh, write and read all pending together
    restart();
    rd_lat = 2; wr_lat = 2; ref_lat = 2;
    init_done = 1'b1;
    repeat (16) cycle();
    ifc.rd_req = 1'b1; ifc.wr_req = 1'b1;
    exp_q.push_back(OWN_REF); exp_q.push_back(OWN_WR); exp_q.push_back(OWN_RD);
    for (int k = 16; k <= 27; k++) begin
      cycle();
      if (k % 4 == 0)      chk("slot_owner", ifc.owner, slot_own[(k - 16) / 4]);
      else if (k % 4 == 3) chk("gap_idle", ifc.busy, 0);
    end
    chk("prio_sb", exp_q.size(), 0);

    // continuous read and write requests
    restart();
    init_done = 1'b1; hold_req = 1'b1;
    ifc.rd_req = 1'b1; ifc.wr_req = 1'b1;
`ifdef SDR_ARB_RR_EN
    exp_q.push_back(OWN_WR); exp_q.push_back(OWN_RD); exp_q.push_back(OWN_WR);
`else
    exp_q.push_back(OWN_WR); exp_q.push_back(OWN_WR); exp_q.push_back(OWN_WR);
`endif
    for (int k = 0; k <= 12; k++) begin
      cycle();
      if (k == 9) begin
        ifc.rd_req = 1'b0; ifc.wr_req = 1'b0; hold_req = 1'b0;
      end
    end
    chk("cont_idle", ifc.busy, 0);
    chk("cont_sb", exp_q.size(), 0);

    // read with done withheld -> timeout after 8 cycles
    restart();
    init_done = 1'b1; ifc.rd_req = 1'b1; rd_lat = 0;
    exp_q.push_back(OWN_RD);
    for (int k = 0; k <= 8; k++) cycle();
    chk("pre_to_err", ifc.err, 0);
    chk("pre_to_owner", ifc.owner, OWN_RD);
    cycle();
    chk("to_err", ifc.err, 1);
    chk("to_busy", ifc.busy, 0);
    chk("to_owner", ifc.owner, OWN_NONE);
    repeat (3) cycle();
    chk("to_err_sticky", ifc.err, 1);
    restart();
    chk("to_err_init", ifc.err, 1);

    // reset in the middle of a read
    init_done = 1'b1; ifc.rd_req = 1'b1; rd_lat = 0;
    exp_q.push_back(OWN_RD);
    repeat (4) cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_owner", ifc.owner, OWN_NONE);
    chk("mid_rst_busy", ifc.busy, 1);
    chk("mid_rst_err", ifc.err, 0);
    chk("mid_rst_pulses", pulses_a(), 0);
    repeat (2) cycle();
    ifc.rd_req = 1'b1; rd_lat = 2;
    rst_n = 1'b1;
    cycle();
    chk("rel_pulses", pulses_a(), 0);
    exp_q.push_back(OWN_RD);
    cycle();
    repeat (3) cycle();
    chk("rel_rd_idle", ifc.busy, 0);
    chk("rel_sb", exp_q.size(), 0);

    // init_done dropped while reading
    restart();
    ifc.rd_req = 1'b1; rd_lat = 0; init_done = 1'b1;
    exp_q.push_back(OWN_RD);
    repeat (3) cycle();
    chk("drop_pre_owner", ifc.owner, OWN_RD);
    init_done = 1'b0;
    cycle();
    chk("drop_owner", ifc.owner, OWN_NONE);
    chk("drop_busy", ifc.busy, 1);
    ifc.rd_req = 1'b1;
    repeat (4) cycle();
    chk("drop_hold_busy", ifc.busy, 1);
    init_done = 1'b1; rd_lat = 2;
    exp_q.push_back(OWN_RD);
    repeat (5) cycle();
    chk("drop_resume_idle", ifc.busy, 0);
    chk("drop_sb", exp_q.size(), 0);

    // long write spans two refresh terminal counts (TO_CYCLES = 64 instance)
    rst_n = 1'b0; init_done = 1'b0; rst_n_b = 1'b1;
    cycle();
    cycle();
    ifc_b.wr_req = 1'b1; wr_lat_b = 40; ref_lat_b = 2;
    init_done = 1'b1;
    exp_q_b.push_back(OWN_WR); exp_q_b.push_back(OWN_REF);
    for (int k = 0; k <= 43; k++) begin
      cycle();
      if (k == 30) chk("ovr_err_before", ifc_b.err, 0);
      if (k == 31) chk("ovr_err_at_tc2", ifc_b.err, 1);
      if (k == 41) chk("ovr_wr_owner", ifc_b.owner, OWN_WR);
      if (k == 42) begin
        chk("ovr_wr_end_owner", ifc_b.owner, OWN_NONE);
        chk("ovr_wr_end_busy", ifc_b.busy, 0);
      end
    end
    chk("ovr_sb", exp_q_b.size(), 0);
    chk("final_sb", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
